// File: rtl/des_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : des_round_ctrl                                               |
// | Description : Iterative DES round controller. Accepts one pre-permuted     |
// |               64-bit block and a 64-bit key, drives the external key       |
// |               schedule, runs 16 Feistel rounds (one per clock) through an  |
// |               external combinational f-function and returns {R16, L16}.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n            : clock, synchronous active-low reset              |
// |   in_valid/in_ready     : input handshake (ready only in IDLE)             |
// |   in_block              : {L0, R0} after initial permutation               |
// |   in_key, in_decrypt    : raw key and mode, sampled with the block         |
// |   ks_init_key           : latched key to the key schedule                  |
// |   ks_encrypt_decrypt    : latched mode to the key schedule                 |
// |   ks_round_keys         : 16 x 48-bit round keys, round k at [767-48k -:48]|
// |   f_r, f_key, f_out     : f-function operands and result                   |
// |   out_valid/out_ready   : output handshake                                 |
// |   out_block             : {R16, L16}                                       |
// |   busy, round_idx       : status                                           |
// +----------------------------------------------------------------------------+
module des_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [63:0]  in_key,
  input  logic         in_decrypt,
  output logic [63:0]  ks_init_key,
  output logic         ks_encrypt_decrypt,
  input  logic [767:0] ks_round_keys,
  output logic [31:0]  f_r,
  output logic [47:0]  f_key,
  input  logic [31:0]  f_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
  output logic         busy,
  output logic [3:0]   round_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_LAST_ROUND = 4'd15;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_l;
  logic [31:0] w_l_nxt;
  logic [31:0] r_r;
  logic [31:0] w_r_nxt;
  logic [63:0] r_key;
  logic [63:0] w_key_nxt;
  logic        r_mode;
  logic        w_mode_nxt;
  logic [3:0]  r_round_idx;
  logic [3:0]  w_round_idx_nxt;

  // Unpack the flat round-key bus so the current key is a simple indexed read.
  logic [47:0] w_round_keys [16];

  for (genvar k = 0; k < 16; k++) begin : g_key_unpack
    assign w_round_keys[k] = ks_round_keys[767-48*k -: 48];
  end

  // Next-state and datapath update
  always_comb begin
    w_state_nxt     = r_state;
    w_l_nxt         = r_l;
    w_r_nxt         = r_r;
    w_key_nxt       = r_key;
    w_mode_nxt      = r_mode;
    w_round_idx_nxt = r_round_idx;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_l_nxt     = in_block[63:32];
          w_r_nxt     = in_block[31:0];
          w_key_nxt   = in_key;
          w_mode_nxt  = in_decrypt;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // Key schedule is combinational on r_key/r_mode; give it a cycle.
        w_round_idx_nxt = 4'd0;
        w_state_nxt     = ST_ROUND;
      end
      ST_ROUND: begin
        w_l_nxt         = r_r;
        w_r_nxt         = r_l ^ f_out;
        w_round_idx_nxt = r_round_idx + 4'd1;
        if (r_round_idx == C_LAST_ROUND) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_l         <= 32'd0;
      r_r         <= 32'd0;
      r_key       <= 64'd0;
      r_mode      <= 1'b0;
      r_round_idx <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_l         <= w_l_nxt;
      r_r         <= w_r_nxt;
      r_key       <= w_key_nxt;
      r_mode      <= w_mode_nxt;
      r_round_idx <= w_round_idx_nxt;
    end
  end

  assign in_ready           = (r_state == ST_IDLE);
  assign busy               = (r_state != ST_IDLE);
  assign out_valid          = (r_state == ST_DONE);
  // Final swap: the last round leaves L/R in swapped order, so emit {R, L}.
  assign out_block          = {r_r, r_l};
  assign ks_init_key        = r_key;
  assign ks_encrypt_decrypt = r_mode;
  assign f_r                = r_r;
  assign f_key              = w_round_keys[r_round_idx];
  assign round_idx          = r_round_idx;

endmodule
`default_nettype wire
